neuron_mac_parallel: RTL and testbench
======================================

Name: neuron_mac_parallel

Overview:
- Multi-lane successor to the single-MAC neuron. Computes one neuron output, dot(in_data, weight) + bias, using LANES multiply-accumulates per cycle.
- Adds a post-processing stage: arithmetic right-shift requantisation, optional ReLU and saturation to WIDTH_OUT.
- Uses a start/busy/valid/ready handshake so a layer controller can chain neurons with backpressure.

Parameters:
- IN_SIZE, 196: number of input elements and weights.
- LANES, 4: parallel multipliers; products summed per cycle.
- WIDTH_IN, 8: signed input element width.
- WIDTH_W, 8: signed weight and bias width.
- WIDTH_ACC, 32: accumulator width.
- WIDTH_OUT, 16: signed output width after requantisation.
- CHUNKS (localparam), ceil(IN_SIZE/LANES): MAC cycles per neuron.

Ports:
- clk, input, 1: clock.
- reset, input, 1: synchronous, active-high reset.
- start, input, 1: request a computation; accepted per the rules below.
- in_data, input, WIDTH_IN*IN_SIZE: flattened signed inputs; element i at bits [(i+1)*WIDTH_IN-1 -: WIDTH_IN].
- weight, input, WIDTH_W*IN_SIZE: flattened signed weights, same packing.
- bias, input, WIDTH_W: signed bias.
- shift, input, 5: requantisation right-shift amount, 0..31.
- relu_en, input, 1: 1 = clamp negative results to 0.
- out_ready, input, 1: downstream accepts the result.
- busy, output, 1: high in MAC and POST.
- out_valid, output, 1: result available.
- out_data, output, WIDTH_OUT: signed saturated result.
- acc_out, output, WIDTH_ACC: accumulator + bias, before shift, ReLU and saturation (debug and verification).

Behaviour:
- Reset: state IDLE; out_valid=0, busy=0, out_data=0, acc_out=0, accumulator=0, chunk index=0.
- Reset asserted in any state, including mid-MAC, aborts the computation and restores reset values on the next edge. No partial result is ever presented.
- States: IDLE, MAC, POST, VALID.
- IDLE:
  - start=1 at an edge: capture bias, shift and relu_en; clear accumulator; index=0; go to MAC.
  - start=0: stay in IDLE.
- MAC:
  - Each edge: accumulator += sum over lanes l of in_data[index*LANES+l] * weight[index*LANES+l].
  - Lanes with element number >= IN_SIZE contribute 0 (zero padding).
  - Products are signed, full width WIDTH_IN+WIDTH_W, sign-extended to WIDTH_ACC.
  - The accumulator wraps modulo 2^WIDTH_ACC; there is no internal saturation.
  - index increments each edge. After the edge that accumulates chunk CHUNKS-1, go to POST.
- POST (one cycle), registered at the edge leaving POST:
  - biased = acc + sign-extended bias (wrapping), driven to acc_out.
  - shifted = biased >>> shift (arithmetic, floor toward -inf).
  - If relu_en and shifted < 0, then 0.
  - Saturate to [-2^(WIDTH_OUT-1), 2^(WIDTH_OUT-1)-1] and drive to out_data.
  - Go to VALID with out_valid=1.
- Latency: start accepted at edge k gives out_valid=1 after edge k+CHUNKS+1 (e.g. 50 cycles for the defaults).
- VALID:
  - out_valid=1; out_data and acc_out held stable until out_ready=1.
  - out_ready=1 and start=0: go to IDLE, out_valid=0 next cycle; out_data keeps its last value.
  - out_ready=1 and start=1 in the same cycle: handshake completes and the new start is accepted; go straight to MAC with no idle cycle.
  - start with out_ready=0: ignored.
- start while busy is ignored.
- in_data and weight are read combinationally during MAC. The caller holds them stable from start acceptance until busy falls.
- bias, shift and relu_en changes after acceptance do not affect the current computation.

Test Plan:
- Defaults, all in_data=1, weight=1, bias=0, shift=0, relu_en=0, start pulse:
  - busy high 50 cycles;
  - out_valid after 50 cycles;
  - out_data=196, acc_out=196.
- All in_data=127, weight=127, bias=0:
  - shift=0: acc_out=3161284, out_data=32767 (saturated).
  - Repeat with shift=8: out_data=12348.
- in_data=1, weight=-1, bias=-4:
  - relu_en=0: out_data=-200.
  - relu_en=1: out_data=0, acc_out=-200 in both cases.
- IN_SIZE=5, LANES=4, inputs 1..5, weights 1, bias=3:
  - CHUNKS=2 and padding lanes are ignored;
  - out_valid 3 cycles after start;
  - out_data=18.
- Backpressure and chaining:
  - Hold out_ready=0 for 10 cycles: out_valid and out_data stable; a start pulse during this time is ignored.
  - Then assert out_ready=1 and start=1 together: new MAC begins next cycle and a second result appears 50 cycles later.
- Reset 20 cycles into MAC:
  - all outputs 0 next cycle, state IDLE;
  - a following start yields the correct full result.

Source files
------------

// File: rtl/neuron_mac_parallel.sv
// Purpose : one neuron output, dot(in_data, weight) + bias, LANES MACs per cycle,
//           followed by arithmetic-shift requantisation, optional ReLU and saturation.
// Latency : start accepted at edge k -> out_valid after edge k+CHUNKS+1.
// Backpr. : result held in VALID until out_ready; start ignored while busy or while
//           VALID without out_ready. A start together with out_ready chains straight into MAC.
// Ports   : clk/reset (sync, active-high); start; in_data/weight (flattened, element i at
//           [(i+1)*W-1 -: W]); bias/shift/relu_en captured at accept; out_ready;
//           busy (MAC or POST); out_valid/out_data result; acc_out = acc + bias (pre-shift).
module neuron_mac_parallel #(
    parameter int IN_SIZE   = 196,
    parameter int LANES     = 4,
    parameter int WIDTH_IN  = 8,
    parameter int WIDTH_W   = 8,
    parameter int WIDTH_ACC = 32,
    parameter int WIDTH_OUT = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [WIDTH_IN*IN_SIZE-1:0]   in_data,
    input  logic [WIDTH_W*IN_SIZE-1:0]    weight,
    input  logic [WIDTH_W-1:0]            bias,
    input  logic [4:0]                    shift,
    input  logic                          relu_en,
    input  logic                          out_ready,
    output logic                          busy,
    output logic                          out_valid,
    output logic [WIDTH_OUT-1:0]          out_data,
    output logic [WIDTH_ACC-1:0]          acc_out
);

    localparam int CHUNKS = (IN_SIZE + LANES - 1) / LANES;
    localparam int PADDED = CHUNKS * LANES;
    localparam int IDX_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int PROD_W = WIDTH_IN + WIDTH_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);

    // Saturation bounds, sign-extended to accumulator width.
    localparam logic signed [WIDTH_ACC-1:0] OUT_MAX =
        {{(WIDTH_ACC-WIDTH_OUT+1){1'b0}}, {(WIDTH_OUT-1){1'b1}}};
    localparam logic signed [WIDTH_ACC-1:0] OUT_MIN =
        {{(WIDTH_ACC-WIDTH_OUT+1){1'b1}}, {(WIDTH_OUT-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_POST,
        S_VALID
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH_ACC-1:0]        acc;
    logic [IDX_W-1:0]            idx;
    logic [WIDTH_W-1:0]          bias_r;
    logic [4:0]                  shift_r;
    logic                        relu_r;

    logic                        accept;
    logic [WIDTH_IN*PADDED-1:0]  in_pad;
    logic [WIDTH_W*PADDED-1:0]   w_pad;
    logic [PROD_W-1:0]           a_ext;
    logic [PROD_W-1:0]           b_ext;
    logic [PROD_W-1:0]           prod;
    logic [WIDTH_ACC-1:0]        chunk_sum;

    logic signed [WIDTH_ACC-1:0] biased;
    logic signed [WIDTH_ACC-1:0] shifted;
    logic signed [WIDTH_ACC-1:0] clipped;
    logic signed [WIDTH_ACC-1:0] sat_val;

    assign accept    = start && ((state == S_IDLE) || (state == S_VALID && out_ready));
    assign busy      = (state == S_MAC) || (state == S_POST);
    assign out_valid = (state == S_VALID);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_MAC;
            S_MAC:   if (idx == LAST_IDX) state_nxt = S_POST;
            S_POST:  state_nxt = S_VALID;
            S_VALID: if (out_ready) state_nxt = start ? S_MAC : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Vectors are zero-padded to a whole number of chunks, so lanes past
    // IN_SIZE multiply zeros and never index outside the real inputs.
    always_comb begin
        in_pad    = '0;
        w_pad     = '0;
        in_pad[WIDTH_IN*IN_SIZE-1:0] = in_data;
        w_pad[WIDTH_W*IN_SIZE-1:0]   = weight;
        a_ext     = '0;
        b_ext     = '0;
        prod      = '0;
        chunk_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            a_ext = {{WIDTH_W{1'b0}}, in_pad[(int'(idx)*LANES + l)*WIDTH_IN +: WIDTH_IN]};
            b_ext = {{WIDTH_IN{1'b0}}, w_pad[(int'(idx)*LANES + l)*WIDTH_W +: WIDTH_W]};
            // Sign-extend both operands to the full product width so the
            // low PROD_W bits of the unsigned multiply are the signed product.
            a_ext[PROD_W-1:WIDTH_IN] = {WIDTH_W{a_ext[WIDTH_IN-1]}};
            b_ext[PROD_W-1:WIDTH_W]  = {WIDTH_IN{b_ext[WIDTH_W-1]}};
            prod      = a_ext * b_ext;
            chunk_sum = chunk_sum + {{(WIDTH_ACC-PROD_W){prod[PROD_W-1]}}, prod};
        end
    end

    always_comb begin
        biased  = $signed(acc + {{(WIDTH_ACC-WIDTH_W){bias_r[WIDTH_W-1]}}, bias_r});
        shifted = biased >>> shift_r;
        clipped = (relu_r && shifted[WIDTH_ACC-1]) ? '0 : shifted;
        if (clipped > OUT_MAX) begin
            sat_val = OUT_MAX;
        end else if (clipped < OUT_MIN) begin
            sat_val = OUT_MIN;
        end else begin
            sat_val = clipped;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc      <= '0;
            idx      <= '0;
            bias_r   <= '0;
            shift_r  <= '0;
            relu_r   <= 1'b0;
            out_data <= '0;
            acc_out  <= '0;
        end else begin
            if (accept) begin
                acc     <= '0;
                idx     <= '0;
                bias_r  <= bias;
                shift_r <= shift;
                relu_r  <= relu_en;
            end else if (state == S_MAC) begin
                acc <= acc + chunk_sum;
                idx <= idx + IDX_W'(1);
            end
            if (state == S_POST) begin
                acc_out  <= biased;
                out_data <= sat_val[WIDTH_OUT-1:0];
            end
        end
    end

endmodule

// File: tb/tb_neuron_mac_parallel.sv
// Purpose : directed bench for neuron_mac_parallel (default size plus a 5-input instance).
// Latency : checks out_valid at CHUNKS+1 edges after start acceptance.
// Backpr. : exercises held results, ignored starts and back-to-back chaining.
module tb_neuron_mac_parallel;

    localparam int N  = 196;
    localparam int NS = 5;

    logic clk = 1'b0;
    logic reset;

    // Default-size instance
    logic              start, relu_en, out_ready;
    logic [8*N-1:0]    in_data, weight;
    logic [7:0]        bias;
    logic [4:0]        shift;
    logic              busy, out_valid;
    logic signed [15:0] out_data;
    logic signed [31:0] acc_out;

    // Small instance: IN_SIZE=5, LANES=4
    logic              s_start, s_relu_en, s_out_ready;
    logic [8*NS-1:0]   s_in_data, s_weight;
    logic [7:0]        s_bias;
    logic [4:0]        s_shift;
    logic              s_busy, s_out_valid;
    logic signed [15:0] s_out_data;
    logic signed [31:0] s_acc_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    neuron_mac_parallel dut (
        .clk(clk), .reset(reset), .start(start), .in_data(in_data), .weight(weight),
        .bias(bias), .shift(shift), .relu_en(relu_en), .out_ready(out_ready),
        .busy(busy), .out_valid(out_valid), .out_data(out_data), .acc_out(acc_out)
    );

    neuron_mac_parallel #(.IN_SIZE(NS), .LANES(4)) dut_s (
        .clk(clk), .reset(reset), .start(s_start), .in_data(s_in_data), .weight(s_weight),
        .bias(s_bias), .shift(s_shift), .relu_en(s_relu_en), .out_ready(s_out_ready),
        .busy(s_busy), .out_valid(s_out_valid), .out_data(s_out_data), .acc_out(s_acc_out)
    );

    typedef struct {
        logic signed [7:0]  in_v;
        logic signed [7:0]  w_v;
        logic signed [7:0]  b;
        logic [4:0]         sh;
        logic               relu;
        bit                 pattern;   // per-element varying data instead of constants
        longint             exp_out;
        longint             exp_acc;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic longint pat_in(input int i);
        return longint'(i % 7) - 3;
    endfunction

    function automatic longint pat_w(input int i);
        return longint'(i % 5) - 2;
    endfunction

    // Reference for the pattern vector: plain integer arithmetic.
    function automatic longint ref_out(input longint biased, input int sh, input bit relu);
        longint v;
        v = biased >>> sh;
        if (relu && v < 0) v = 0;
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        return v;
    endfunction

    task automatic load(input vec_t v);
        for (int i = 0; i < N; i++) begin
            in_data[i*8 +: 8] = v.pattern ? 8'(pat_in(i)) : v.in_v;
            weight[i*8 +: 8]  = v.pattern ? 8'(pat_w(i))  : v.w_v;
        end
        bias    = v.b;
        shift   = v.sh;
        relu_en = v.relu;
    endtask

    // Pulse start (optionally a stray start mid-MAC), wait for out_valid,
    // check latency, busy length and the result.
    task automatic run_and_check(input string tag, input longint e_out, input longint e_acc,
                                 input bit with_ready);
        int j;
        int busy_cnt;
        start     = 1'b1;
        out_ready = with_ready;
        @(negedge clk);
        start     = 1'b0;
        out_ready = 1'b0;
        j = 0;
        busy_cnt = 0;
        while (!out_valid && j < 200) begin
            if (busy) busy_cnt++;
            if (j == 10) start = 1'b1;      // must be ignored while busy
            else start = 1'b0;
            @(negedge clk);
            j++;
        end
        start = 1'b0;
        chk({tag, " latency"}, j, 50);
        chk({tag, " busy_cycles"}, busy_cnt, 50);
        chk({tag, " out_data"}, out_data, e_out);
        chk({tag, " acc_out"}, acc_out, e_acc);
    endtask

    task automatic consume(input string tag, input longint e_out);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, " valid_drop"}, out_valid, 0);
        chk({tag, " out_hold"}, out_data, e_out);
    endtask

    initial begin
        longint psum;
        int     k;
        reset = 1'b1;
        start = 1'b0; out_ready = 1'b0; relu_en = 1'b0; bias = '0; shift = '0;
        in_data = '0; weight = '0;
        s_start = 1'b0; s_out_ready = 1'b0; s_relu_en = 1'b0; s_bias = '0; s_shift = '0;
        s_in_data = '0; s_weight = '0;

        //           in    w    b   sh relu pat  out     acc
        vecs[0] = '{   1,   1,   0, 0, 0, 0,     196,      196};
        vecs[1] = '{ 127, 127,   0, 0, 0, 0,   32767,  3161284};
        vecs[2] = '{ 127, 127,   0, 8, 0, 0,   12348,  3161284};
        vecs[3] = '{   1,  -1,  -4, 0, 0, 0,    -200,     -200};
        vecs[4] = '{   1,  -1,  -4, 0, 1, 0,       0,     -200};
        vecs[5] = '{-128, 127,   0, 4, 0, 0,  -32768, -3186176};
        vecs[6] = '{  -3,   5,   7, 3, 0, 0,    -367,    -2933};
        psum = 5;
        for (int i = 0; i < N; i++) psum += pat_in(i) * pat_w(i);
        vecs[7] = '{   0,   0,   5, 2, 0, 1, ref_out(psum, 2, 1'b0), psum};

        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("reset out_valid", out_valid, 0);
        chk("reset busy", busy, 0);
        chk("reset out_data", out_data, 0);
        chk("reset acc_out", acc_out, 0);
        chk("reset s_out_valid", s_out_valid, 0);

        foreach (vecs[i]) begin
            load(vecs[i]);
            run_and_check($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_acc, 1'b0);
            consume($sformatf("vec%0d", i), vecs[i].exp_out);
            @(negedge clk);
        end

        // Padding lanes: 5 inputs, 2 chunks, result 1+2+3+4+5+3 = 18.
        for (int i = 0; i < NS; i++) begin
            s_in_data[i*8 +: 8] = 8'(i + 1);
            s_weight[i*8 +: 8]  = 8'd1;
        end
        s_bias = 8'd3;
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        k = 0;
        while (!s_out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("small latency", k, 3);
        chk("small out_data", s_out_data, 18);
        chk("small acc_out", s_acc_out, 18);
        s_out_ready = 1'b1;
        @(negedge clk);
        s_out_ready = 1'b0;
        chk("small valid_drop", s_out_valid, 0);

        // Backpressure: hold result, ignore start, then chain with ready+start.
        load(vecs[0]);
        run_and_check("bp first", 196, 196, 1'b0);
        for (int c = 0; c < 10; c++) begin
            start = (c == 5);
            @(negedge clk);
            chk($sformatf("bp hold valid c%0d", c), out_valid, 1);
            chk($sformatf("bp hold data c%0d", c), out_data, 196);
        end
        start = 1'b0;
        chk("bp no busy", busy, 0);
        for (int i = 0; i < N; i++) in_data[i*8 +: 8] = 8'd2;
        run_and_check("bp chained", 392, 392, 1'b1);
        consume("bp chained", 392);

        // Reset 20 cycles into MAC, then a clean rerun.
        load(vecs[3]);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        chk("pre-reset busy", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid reset busy", busy, 0);
        chk("mid reset out_valid", out_valid, 0);
        chk("mid reset out_data", out_data, 0);
        chk("mid reset acc_out", acc_out, 0);
        repeat (3) @(negedge clk);
        chk("post reset idle", busy, 0);
        load(vecs[0]);
        run_and_check("after reset", 196, 196, 1'b0);
        consume("after reset", 196);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
